// File: rtl/parity_check_rx.sv
// parity_check_rx: even-parity checker feeding a small FIFO, with saturating error accounting.
// Build option PCHK_DROP_BAD_EN: words failing parity are counted but never buffered.
module parity_check_rx #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4:0]                in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [3:0]                out_data,
   output logic                      out_perr,
   output logic [CNT_W-1:0]          err_cnt,
   output logic                      err_sticky,
   input  logic                      clr_err,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [3:0]       mem_data_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_sticky_q, err_sticky_d;
   logic             full, empty, accept, pop, perr, wr_en;

   assign perr  = ^in_data;
   assign full  = (count_q == FULL_LVL);
   assign empty = (count_q == '0);

   // Gate with rst so in_ready reads 0 for the whole reset interval.
   assign in_ready = !rst && !full;
   assign accept   = in_valid && in_ready;
   assign pop      = !empty && out_ready;

`ifdef PCHK_DROP_BAD_EN
   assign wr_en = accept && !perr;
`else
   assign wr_en = accept;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Clear takes effect first so a coincident error still lands on the fresh count.
   always_comb begin
      err_cnt_d    = err_cnt_q;
      err_sticky_d = err_sticky_q;
      if (clr_err) begin
         err_cnt_d    = '0;
         err_sticky_d = 1'b0;
      end
      if (accept && perr) begin
         if (err_cnt_d != CNT_MAX) err_cnt_d = err_cnt_d + 1'b1;
         err_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_cnt_q    <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_cnt_q    <= err_cnt_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Storage is reset so the head reads 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_data_q[i] <= '0;
      end else if (wr_en) begin
         mem_data_q[wr_ptr_q] <= in_data[3:0];
      end
   end

`ifdef PCHK_DROP_BAD_EN
   assign out_perr = 1'b0;
`else
   logic mem_perr_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_perr_q[i] <= 1'b0;
      end else if (wr_en) begin
         mem_perr_q[wr_ptr_q] <= perr;
      end
   end

   assign out_perr = mem_perr_q[rd_ptr_q];
`endif

   assign out_valid  = !empty;
   assign out_data   = mem_data_q[rd_ptr_q];
   assign err_cnt    = err_cnt_q;
   assign err_sticky = err_sticky_q;
   assign level      = count_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: directed scenarios plus randomized traffic checked against a queue-based
// reference model of the parity-checking FIFO.
module tb_parity_check_rx;

   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [4:0]       in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [3:0]       out_data;
   logic             out_perr;
   logic [CNT_W-1:0] err_cnt;
   logic             err_sticky;
   logic             clr_err = 1'b0;
   logic [LW-1:0]    level;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of {perr, payload}, plus error counters.
   logic [4:0] mq[$];
   int         m_cnt    = 0;
   bit         m_sticky = 1'b0;

   always #5 clk = ~clk;

   parity_check_rx #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_perr   (out_perr),
      .err_cnt    (err_cnt),
      .err_sticky (err_sticky),
      .clr_err    (clr_err),
      .level      (level)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] mk(input logic [3:0] d, input bit bad);
      mk = {(^d) ^ bad, d};
   endfunction

   task automatic check_model();
      check_eq("level", 32'(level), 32'(mq.size()));
      check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
      check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
      if (mq.size() != 0) begin
         check_eq("out_data", 32'(out_data), 32'(mq[0][3:0]));
         check_eq("out_perr", 32'(out_perr), 32'(mq[0][4]));
      end
   endtask

   // One clock cycle: called at negedge, drives inputs, checks, advances the model.
   task automatic step(input bit v, input logic [4:0] d, input bit ordy, input bit clr);
      bit acc, pop, bad;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      clr_err   = clr;
      #1;
      check_model();
      bad = ($countones(d) % 2) == 1;
      acc = v && (mq.size() < DEPTH);
      pop = (mq.size() > 0) && ordy;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
`ifdef PCHK_DROP_BAD_EN
      if (acc && !bad) mq.push_back({1'b0, d[3:0]});
`else
      if (acc) mq.push_back({bad, d[3:0]});
`endif
      if (clr) begin
         m_cnt    = 0;
         m_sticky = 1'b0;
      end
      if (acc && bad) begin
         if (m_cnt < CMAX) m_cnt++;
         m_sticky = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
      check_eq({tag, "_out_data"}, 32'(out_data), 0);
      check_eq({tag, "_out_perr"}, 32'(out_perr), 0);
      check_eq({tag, "_err_cnt"}, 32'(err_cnt), 0);
      check_eq({tag, "_err_sticky"}, 32'(err_sticky), 0);
      check_eq({tag, "_level"}, 32'(level), 0);
      check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
   endtask

   // Assert reset asynchronously (mid-cycle), hold for some edges, release at a negedge.
   task automatic do_reset(input int cycles);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clr_err = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      mq.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
   endtask

   initial begin
      do_reset(3);
      step(1'b0, 5'h00, 1'b0, 1'b0);
      check_eq("post_rst_in_ready", 32'(in_ready), 1);

      // Good word passes through with one cycle latency.
      step(1'b1, 5'b0_0110, 1'b1, 1'b0);
      check_eq("t2_out_valid", 32'(out_valid), 1);
      check_eq("t2_out_data", 32'(out_data), 32'h6);
      check_eq("t2_out_perr", 32'(out_perr), 0);
      check_eq("t2_err_cnt", 32'(err_cnt), 0);

      // Bad-parity word.
      step(1'b1, 5'b1_0110, 1'b1, 1'b0);
`ifdef PCHK_DROP_BAD_EN
      check_eq("t3_out_valid", 32'(out_valid), 0);
`else
      check_eq("t3_out_data", 32'(out_data), 32'h6);
      check_eq("t3_out_perr", 32'(out_perr), 1);
`endif
      check_eq("t3_err_cnt", 32'(err_cnt), 1);
      check_eq("t3_err_sticky", 32'(err_sticky), 1);
      step(1'b0, 5'h00, 1'b1, 1'b0);

      // Fill to full, refuse a fifth word, drain in order.
      for (int i = 1; i <= 4; i++) step(1'b1, mk(4'(i), 1'b0), 1'b0, 1'b0);
      check_eq("t4_level_full", 32'(level), 4);
      check_eq("t4_in_ready_full", 32'(in_ready), 0);
      step(1'b1, mk(4'h5, 1'b0), 1'b1, 1'b0);
      check_eq("t4_full_pop_level", 32'(level), 3);
      for (int i = 2; i <= 4; i++) begin
         check_eq("t4_order", 32'(out_data), 32'(i));
         step(1'b0, 5'h00, 1'b1, 1'b0);
      end
      check_eq("t4_level_empty", 32'(level), 0);

      // Simultaneous push and pop at level 2.
      step(1'b1, mk(4'hA, 1'b0), 1'b0, 1'b0);
      step(1'b1, mk(4'hB, 1'b0), 1'b0, 1'b0);
      check_eq("t5_head", 32'(out_data), 32'hA);
      step(1'b1, mk(4'hC, 1'b0), 1'b1, 1'b0);
      check_eq("t5_level", 32'(level), 2);
      check_eq("t5_head_after", 32'(out_data), 32'hB);
      step(1'b0, 5'h00, 1'b1, 1'b0);
      step(1'b0, 5'h00, 1'b1, 1'b0);

      // Saturation and clear ordering.
      step(1'b0, 5'h00, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, mk(4'(i), 1'b1), 1'b1, 1'b0);
      check_eq("t6_sat", 32'(err_cnt), CMAX);
      step(1'b0, 5'h00, 1'b1, 1'b1);
      check_eq("t6_clr_cnt", 32'(err_cnt), 0);
      check_eq("t6_clr_sticky", 32'(err_sticky), 0);
      step(1'b1, mk(4'h9, 1'b1), 1'b1, 1'b1);
      check_eq("t6_clr_err_cnt", 32'(err_cnt), 1);
      check_eq("t6_clr_err_sticky", 32'(err_sticky), 1);

      // Randomized traffic, with phases biased toward full and toward empty.
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 600; n++) begin
            bit v, o, c;
            v = $urandom_range(0, 3) != 0;
            o = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                (ph == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            c = $urandom_range(0, 15) == 0;
            step(v, 5'($urandom), o, c);
         end
      end

      // Reset in the middle of traffic discards everything.
      for (int i = 0; i < 3; i++) step(1'b1, mk(4'(i + 3), i == 1), 1'b0, 1'b0);
      do_reset(2);
      step(1'b0, 5'h00, 1'b1, 1'b0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 1);
      step(1'b1, mk(4'hE, 1'b0), 1'b1, 1'b0);
      step(1'b0, 5'h00, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
